// File: rtl/sd_card_pkg.sv
// Shared types and constants for the SD card-side CMD responder.
package sd_card_pkg;

    typedef enum logic [1:0] {
        RSP_NONE      = 2'd0,
        RSP_R48       = 2'd1,
        RSP_R48_NOCRC = 2'd2,
        RSP_R136      = 2'd3
    } rsp_type_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX,
        ST_CHECK,
        ST_WAIT_RSP,
        ST_HOLD,
        ST_TX,
        ST_NRC
    } state_e;

    localparam logic [6:0]  CRC7_POLY     = 7'h09;
    localparam int unsigned CMD_FRAME_LEN = 48;
    localparam int unsigned R2_FRAME_LEN  = 136;

    function automatic logic [7:0] frame_bits(input rsp_type_e t);
        return (t == RSP_R136) ? 8'(R2_FRAME_LEN) : 8'(CMD_FRAME_LEN);
    endfunction

    // MSB-first, left-aligned; R48 CRC slots hold 7'h7F and are replaced while shifting out.
    function automatic logic [135:0] build_tx_frame(input rsp_type_e t, input logic [127:0] d);
        if (t == RSP_R136) begin
            return {2'b00, 6'h3F, d[127:1], 1'b1};
        end
        return {2'b00, d[37:0], 7'h7F, 1'b1, 88'b0};
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), one bit per clock, synchronous clear.
module sd_crc7
    import sd_card_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [6:0] crc_o
);

    logic [6:0] crc_q, crc_d;
    logic       fb;

    always_comb begin
        fb    = bit_i ^ crc_q[6];
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = '0;
        end else if (en_i) begin
            crc_d = {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD endpoint: receives 48-bit commands, returns R1/R3/R2 responses.
// Define SD_CARD_CMD_CRC_CHECK_EN to enable the received-command CRC7 check.
module sd_card_cmd_responder
    import sd_card_pkg::*;
#(
    parameter int unsigned NcrCycles  = 2,
    parameter int unsigned RspTimeout = 64
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         cmd_i,
    output logic         cmd_o,
    output logic         cmd_en_o,
    output logic         cmd_valid_o,
    output logic [5:0]   cmd_index_o,
    output logic [31:0]  cmd_arg_o,
    output logic         cmd_err_o,
    input  logic         rsp_valid_i,
    output logic         rsp_ready_o,
    input  logic [1:0]   rsp_type_i,
    input  logic [127:0] rsp_data_i,
    output logic         rsp_timeout_o
);

    localparam logic [6:0] NcrLast = 7'(NcrCycles - 1);
    localparam logic [6:0] TmoCnt  = 7'(RspTimeout);

    state_e         state_q, state_d;
    logic [7:0]     bitcnt_q, bitcnt_d, bitcnt_inc;
    logic [6:0]     cnt_q, cnt_d, cnt_inc;
    logic [46:0]    rx_shift_q, rx_shift_d;
    logic [135:0]   tx_shift_q, tx_shift_d;
    rsp_type_e      tx_type_q, tx_type_d;
    logic [5:0]     index_q, index_d;
    logic [31:0]    arg_q, arg_d;
    logic           cmd_q, cmd_d, cmd_en_q, cmd_en_d;
    logic           valid_q, valid_d, err_q, err_d;
    logic           ready_q, ready_d, tmo_q, tmo_d;
    logic           crc_clr, crc_en, crc_bit, crc_ok, tx_bit;
    logic [6:0]     crc;

    sd_crc7 u_crc7 (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (crc_clr),
        .en_i   (crc_en),
        .bit_i  (crc_bit),
        .crc_o  (crc)
    );

    // rx_shift_q holds frame bits 2..48: [46] transmission, [45:40] index, [39:8] arg, [7:1] CRC, [0] end.
    always_comb begin
`ifdef SD_CARD_CMD_CRC_CHECK_EN
        crc_ok = (crc == rx_shift_q[7:1]);
`else
        crc_ok = 1'b1;
`endif
    end

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        cnt_d      = cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        tx_type_d  = tx_type_q;
        index_d    = index_q;
        arg_d      = arg_q;
        cmd_d      = 1'b1;
        cmd_en_d   = 1'b0;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        ready_d    = 1'b0;
        tmo_d      = 1'b0;
        crc_clr    = 1'b0;
        crc_en     = 1'b0;
        crc_bit    = 1'b0;
        tx_bit     = 1'b1;
        bitcnt_inc = (bitcnt_q == '1) ? bitcnt_q : bitcnt_q + 8'd1;
        cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + 7'd1;

        case (state_q)
            ST_IDLE: begin
                if (!cmd_i) begin
                    state_d  = ST_RX;
                    bitcnt_d = 8'd1;
                    crc_clr  = 1'b1;
                end
            end
            ST_RX: begin
                rx_shift_d = {rx_shift_q[45:0], cmd_i};
                bitcnt_d   = bitcnt_inc;
                if (bitcnt_q < 8'd40) begin
                    crc_en  = 1'b1;
                    crc_bit = cmd_i;
                end
                if (bitcnt_inc == 8'(CMD_FRAME_LEN)) begin
                    state_d = ST_CHECK;
                    cnt_d   = '0;
                end
            end
            ST_CHECK: begin
                cnt_d = cnt_inc;
                if (rx_shift_q[46] && rx_shift_q[0] && crc_ok) begin
                    valid_d = 1'b1;
                    index_d = rx_shift_q[45:40];
                    arg_d   = rx_shift_q[39:8];
                    state_d = ST_WAIT_RSP;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_RSP: begin
                cnt_d = cnt_inc;
                if (rsp_valid_i && ready_q) begin
                    tx_type_d  = rsp_type_e'(rsp_type_i);
                    tx_shift_d = build_tx_frame(rsp_type_e'(rsp_type_i), rsp_data_i);
                    state_d    = (rsp_type_e'(rsp_type_i) == RSP_NONE) ? ST_IDLE : ST_HOLD;
                end else if (cnt_q == TmoCnt) begin
                    tmo_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    ready_d = 1'b1;
                end
            end
            ST_HOLD: begin
                cnt_d = cnt_inc;
                if (cnt_q >= NcrLast) begin
                    state_d    = ST_TX;
                    cmd_d      = tx_shift_q[135];
                    cmd_en_d   = 1'b1;
                    tx_shift_d = {tx_shift_q[134:0], 1'b0};
                    bitcnt_d   = 8'd1;
                    crc_clr    = 1'b1;
                end
            end
            ST_TX: begin
                cmd_en_d = 1'b1;
                if (bitcnt_q == frame_bits(tx_type_q)) begin
                    state_d = ST_NRC;
                end else begin
                    // Feeding the CRC its own MSB zeroes the feedback, so it shifts itself out.
                    if (tx_type_q == RSP_R48 && bitcnt_q >= 8'd40 && bitcnt_q < 8'd47) begin
                        tx_bit = crc[6];
                    end else begin
                        tx_bit = tx_shift_q[135];
                    end
                    cmd_d      = tx_bit;
                    tx_shift_d = {tx_shift_q[134:0], 1'b0};
                    bitcnt_d   = bitcnt_inc;
                    if (bitcnt_q < 8'd47) begin
                        crc_en  = 1'b1;
                        crc_bit = tx_bit;
                    end
                end
            end
            ST_NRC: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            bitcnt_q   <= '0;
            cnt_q      <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            tx_type_q  <= RSP_NONE;
            index_q    <= '0;
            arg_q      <= '0;
            cmd_q      <= 1'b1;
            cmd_en_q   <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            ready_q    <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            cnt_q      <= cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            tx_type_q  <= tx_type_d;
            index_q    <= index_d;
            arg_q      <= arg_d;
            cmd_q      <= cmd_d;
            cmd_en_q   <= cmd_en_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
            tmo_q      <= tmo_d;
        end
    end

    assign cmd_o         = cmd_q;
    assign cmd_en_o      = cmd_en_q;
    assign cmd_valid_o   = valid_q;
    assign cmd_index_o   = index_q;
    assign cmd_arg_o     = arg_q;
    assign cmd_err_o     = err_q;
    assign rsp_ready_o   = ready_q;
    assign rsp_timeout_o = tmo_q;

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// Randomized self-checking bench for sd_card_cmd_responder with a frame-level reference model.
module tb_sd_card_cmd_responder;
    import sd_card_pkg::*;

    localparam int unsigned NCR = 8;
    localparam int unsigned TMO = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_i = 1'b1;
    logic         cmd_o, cmd_en_o, cmd_valid_o, cmd_err_o, rsp_ready_o, rsp_timeout_o;
    logic [5:0]   cmd_index_o;
    logic [31:0]  cmd_arg_o;
    logic         rsp_valid_i = 1'b0;
    logic [1:0]   rsp_type_i = 2'd0;
    logic [127:0] rsp_data_i = '0;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int          edge_cnt = 0;

    sd_card_cmd_responder #(.NcrCycles(NCR), .RspTimeout(TMO)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .cmd_i         (cmd_i),
        .cmd_o         (cmd_o),
        .cmd_en_o      (cmd_en_o),
        .cmd_valid_o   (cmd_valid_o),
        .cmd_index_o   (cmd_index_o),
        .cmd_arg_o     (cmd_arg_o),
        .cmd_err_o     (cmd_err_o),
        .rsp_valid_i   (rsp_valid_i),
        .rsp_ready_o   (rsp_ready_o),
        .rsp_type_i    (rsp_type_i),
        .rsp_data_i    (rsp_data_i),
        .rsp_timeout_o (rsp_timeout_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string tag, input logic [135:0] got, input logic [135:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // CRC7 as the remainder of m(x)*x^7 divided by x^7+x^3+1.
    function automatic logic [6:0] crc7(input logic [39:0] m);
        logic [46:0] v;
        v = {m, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
        end
        return v[6:0];
    endfunction

    function automatic logic [47:0] mk_cmd(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] head;
        head = {2'b01, idx, arg};
        return {head, crc7(head), 1'b1};
    endfunction

    function automatic logic [135:0] exp_frame(input logic [1:0] rt, input logic [127:0] d);
        logic [39:0] head;
        head = {2'b00, d[37:0]};
        case (rt)
            RSP_R48:       return {88'b0, head, crc7(head), 1'b1};
            RSP_R48_NOCRC: return {88'b0, head, 7'h7F, 1'b1};
            RSP_R136:      return {2'b00, 6'h3F, d[127:1], 1'b1};
            default:       return '0;
        endcase
    endfunction

    task automatic send_cmd(input logic [47:0] f, output int e);
        for (int i = 47; i >= 0; i--) begin
            @(negedge clk);
            cmd_i = f[i];
        end
        @(negedge clk);
        cmd_i = 1'b1;
        e = edge_cnt;
    endtask

    task automatic offer(input logic [1:0] rt, input logic [127:0] rd);
        rsp_valid_i = 1'b1;
        rsp_type_i  = rt;
        rsp_data_i  = rd;
    endtask

    task automatic run_txn(input string nm, input logic [47:0] f, input logic [1:0] rt,
                           input logic [127:0] rd, input int dly, input bit do_rsp, input int rst_bit);
        int e, k, h, s, len;
        bit good, en_ok, saw_en;
        logic [135:0] got;
        good = f[46] && f[0];
`ifdef SD_CARD_CMD_CRC_CHECK_EN
        good = good && (f[7:1] == crc7(f[47:8]));
`endif
        send_cmd(f, e);
        k = e + dly;
        h = (k + 1 > e + 3) ? k + 1 : e + 3;
        chk({nm, "/valid_at_E"}, 136'(cmd_valid_o), 136'(0));
        if (good && do_rsp && dly == 0) offer(rt, rd);
        @(negedge clk);
        chk({nm, "/cmd_valid"}, 136'(cmd_valid_o), 136'(good));
        chk({nm, "/cmd_err"}, 136'(cmd_err_o), 136'(!good));
        chk({nm, "/ready_E1"}, 136'(rsp_ready_o), 136'(0));
        if (!good) begin
            repeat (4) @(negedge clk);
            chk({nm, "/err_no_drive"}, 136'({cmd_en_o, rsp_ready_o}), 136'(0));
            return;
        end
        chk({nm, "/cmd_index"}, 136'(cmd_index_o), 136'(f[45:40]));
        chk({nm, "/cmd_arg"}, 136'(cmd_arg_o), 136'(f[39:8]));
        if (do_rsp && dly == 1) offer(rt, rd);
        @(negedge clk);
        chk({nm, "/ready_E2"}, 136'(rsp_ready_o), 136'(1));
        if (!do_rsp) begin
            while (edge_cnt < e + int'(TMO)) @(negedge clk);
            chk({nm, "/pre_timeout"}, 136'({rsp_ready_o, rsp_timeout_o}), 136'(2'b10));
            @(negedge clk);
            chk({nm, "/timeout"}, 136'({rsp_ready_o, rsp_timeout_o}), 136'(2'b01));
            @(negedge clk);
            chk({nm, "/post_timeout"}, 136'({rsp_timeout_o, cmd_en_o}), 136'(0));
            return;
        end
        while (edge_cnt < k) @(negedge clk);
        if (dly >= 2) offer(rt, rd);
        while (edge_cnt < h - 1) @(negedge clk);
        chk({nm, "/ready_pre_hs"}, 136'(rsp_ready_o), 136'(1));
        @(negedge clk);
        rsp_valid_i = 1'b0;
        rsp_type_i  = 2'($urandom_range(0, 3));
        rsp_data_i  = {$urandom, $urandom, $urandom, $urandom};
        chk({nm, "/ready_post_hs"}, 136'(rsp_ready_o), 136'(0));
        if (rt == RSP_NONE) begin
            saw_en = 1'b0;
            repeat (8) begin
                @(negedge clk);
                saw_en |= cmd_en_o;
            end
            chk({nm, "/none_no_drive"}, 136'(saw_en), 136'(0));
            return;
        end
        s = (h + 1 > e + int'(NCR)) ? h + 1 : e + int'(NCR);
        while (!cmd_en_o && edge_cnt < s + 16) @(negedge clk);
        if (!cmd_en_o) begin
            chk({nm, "/tx_start_seen"}, 136'(0), 136'(1));
            return;
        end
        chk({nm, "/tx_start_edge"}, 136'(edge_cnt), 136'(s));
        got   = '0;
        en_ok = 1'b1;
        len   = (rt == RSP_R136) ? 136 : 48;
        for (int i = 1; i <= len; i++) begin
            if (i > 1) @(negedge clk);
            if (i == rst_bit) begin
                rst_n = 1'b0;
                #1;
                chk({nm, "/reset_mid_tx"}, 136'({cmd_en_o, cmd_o, rsp_ready_o}), 136'(3'b010));
                @(negedge clk);
                rst_n = 1'b1;
                repeat (2) @(negedge clk);
                return;
            end
            got   = {got[134:0], cmd_o};
            en_ok = en_ok & cmd_en_o;
        end
        chk({nm, "/tx_frame"}, got, exp_frame(rt, rd));
        chk({nm, "/tx_en_held"}, 136'(en_ok), 136'(1));
        @(negedge clk);
        chk({nm, "/nrc_drive"}, 136'({cmd_en_o, cmd_o}), 136'(2'b11));
        @(negedge clk);
        chk({nm, "/nrc_release"}, 136'(cmd_en_o), 136'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks done", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] f;
        logic [1:0]  rt;
        repeat (3) @(negedge clk);
        chk("reset_state",
            136'({cmd_o, cmd_en_o, cmd_valid_o, cmd_err_o, rsp_ready_o, rsp_timeout_o, cmd_index_o, cmd_arg_o}),
            136'({1'b1, 5'b0, 6'd0, 32'd0}));
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        run_txn("cmd0_none", 48'h400000000095, RSP_NONE, '0, 3, 1'b1, 0);
        run_txn("cmd8_r48", 48'h48000001AA87, RSP_R48, {90'b0, 6'd8, 32'h1AA}, 0, 1'b1, 0);
        run_txn("cmd0_badcrc", 48'h400000000001, RSP_R48, {90'b0, 6'd0, 32'h900}, 2, 1'b1, 0);
        run_txn("r48_nocrc", mk_cmd(6'd41, 32'h40FF8000), RSP_R48_NOCRC,
                {90'b0, 6'h3F, 32'h80FF8000}, 5, 1'b1, 0);
        run_txn("r136", mk_cmd(6'd2, 32'h0), RSP_R136,
                128'h0123456789ABCDEF0123456789ABCDEF, 9, 1'b1, 0);
        run_txn("timeout", mk_cmd(6'd55, 32'h0), RSP_R48, '0, 0, 1'b0, 0);
        run_txn("rst_mid_tx", mk_cmd(6'd9, 32'h12340000), RSP_R136,
                {$urandom, $urandom, $urandom, $urandom}, 2, 1'b1, 20);
        run_txn("after_rst", mk_cmd(6'd13, 32'h12340000), RSP_R48, {$urandom, $urandom, $urandom, $urandom}, 4, 1'b1, 0);

        for (int n = 0; n < 30; n++) begin
            f = mk_cmd(6'($urandom_range(0, 63)), $urandom);
            case ($urandom_range(0, 9))
                0: f[1]  = ~f[1];
                1: f[46] = 1'b0;
                2: f[0]  = 1'b0;
                default: ;
            endcase
            rt = 2'($urandom_range(0, 3));
            run_txn($sformatf("rnd%0d", n), f, rt, {$urandom, $urandom, $urandom, $urandom},
                    int'($urandom_range(0, 12)), ($urandom_range(0, 9) != 0), 0);
            repeat (int'($urandom_range(0, 2))) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
